// File: rtl/score_lives_ctrl.sv
// score_lives_ctrl: BCD score, lives, high score and play/dying/over FSM with timed respawn
module score_lives_ctrl #(
  parameter int START_LIVES    = 3,
  parameter int RESPAWN_FRAMES = 120,
  parameter int ROCK_POINTS    = 1
) (
  input  logic        clk_60hz,
  input  logic        reset,
  input  logic        new_game,
  input  logic        rock_hit,
  input  logic        ship_hit,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic        invulnerable,
  output logic        respawn
);
  typedef enum logic [1:0] {PLAY, DYING, OVER} state_t;
  state_t      state, state_n;
  logic [15:0] score_n, high_n;
  logic [1:0]  lives_n;
  logic [7:0]  cnt, cnt_n;
  logic        ng_q, ng_edge, respawn_n;
  function automatic logic [15:0] bcd_add(input logic [15:0] v);
    logic [15:0] r;
    logic [4:0]  s;
    logic        c;
    r = v;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, v[4*i+:4]} + (i == 0 ? 5'(ROCK_POINTS) : 5'd0) + {4'd0, c};
      c = s > 5'd9;
      r[4*i+:4] = c ? 4'(s - 5'd10) : s[3:0];
    end
    return c ? 16'h9999 : r;
  endfunction
  assign ng_edge = new_game & ~ng_q;
  // next-state, score, lives, counter and high-score update; restart overrides everything
  always_comb begin
    state_n   = state;
    score_n   = score;
    high_n    = (state == OVER && score > high_score) ? score : high_score;
    lives_n   = lives;
    cnt_n     = cnt;
    respawn_n = 1'b0;
    if (ng_edge) begin
      state_n   = PLAY;
      score_n   = 16'h0000;
      lives_n   = 2'(START_LIVES);
      cnt_n     = 8'd0;
      respawn_n = 1'b1;
    end else if (state == PLAY) begin
      score_n = rock_hit ? bcd_add(score) : score;
      if (ship_hit) begin
        lives_n = lives - 2'd1;
        state_n = lives > 2'd1 ? DYING : OVER;
        cnt_n   = lives > 2'd1 ? 8'(RESPAWN_FRAMES - 1) : cnt;
      end
    end else if (state == DYING) begin
      state_n   = cnt == 8'd0 ? PLAY : DYING;
      respawn_n = cnt == 8'd0;
      cnt_n     = cnt == 8'd0 ? cnt : cnt - 8'd1;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk_60hz or posedge reset) begin
    if (reset) begin
      state        <= PLAY;
      score        <= 16'h0000;
      high_score   <= 16'h0000;
      lives        <= 2'(START_LIVES);
      cnt          <= 8'd0;
      ng_q         <= 1'b0;
      game_over    <= 1'b0;
      invulnerable <= 1'b0;
      respawn      <= 1'b0;
    end else begin
      state        <= state_n;
      score        <= score_n;
      high_score   <= high_n;
      lives        <= lives_n;
      cnt          <= cnt_n;
      ng_q         <= new_game;
      game_over    <= state_n == OVER;
      invulnerable <= state_n == DYING;
      respawn      <= respawn_n;
    end
  end
endmodule

// File: tb/tb_score_lives_ctrl.sv
// tb_score_lives_ctrl: directed checks of scoring, lives, respawn timing, game over and restart
module tb_score_lives_ctrl;
  logic        clk_60hz = 1'b0;
  logic        reset = 1'b1;
  logic        new_game = 1'b0;
  logic        rock_hit = 1'b0;
  logic        ship_hit = 1'b0;
  logic [15:0] score, high_score;
  logic [1:0]  lives;
  logic        game_over, invulnerable, respawn;
  int          total = 0;
  int          bad = 0;
  int          inv_cnt, rs_cnt, rs_at;

  score_lives_ctrl #(.START_LIVES(3), .RESPAWN_FRAMES(120), .ROCK_POINTS(1)) dut (
    .clk_60hz(clk_60hz), .reset(reset), .new_game(new_game), .rock_hit(rock_hit),
    .ship_hit(ship_hit), .score(score), .high_score(high_score), .lives(lives),
    .game_over(game_over), .invulnerable(invulnerable), .respawn(respawn)
  );

  always #5 clk_60hz = ~clk_60hz;

  task automatic tick();
    @(posedge clk_60hz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [15:0] sc, input logic [15:0] hs, input logic [1:0] lv);
    chk({tag, "_score"}, score, sc);
    chk({tag, "_high"}, high_score, hs);
    chk({tag, "_lives"}, 16'(lives), 16'(lv));
    chk({tag, "_over"}, 16'(game_over), 16'd0);
    chk({tag, "_inv"}, 16'(invulnerable), 16'd0);
    chk({tag, "_respawn"}, 16'(respawn), 16'd0);
  endtask

  initial begin
    tick();
    tick();
    chk_idle("in_reset", 16'h0000, 16'h0000, 2'd3);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle("post_reset", 16'h0000, 16'h0000, 2'd3);
    end

    rock_hit = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    rock_hit = 1'b0;
    chk("rock12", score, 16'h0012);
    rock_hit = 1'b1;
    for (int i = 0; i < 9986; i++) tick();
    chk("rock_9998", score, 16'h9998);
    tick();
    chk("rock_9999", score, 16'h9999);
    for (int i = 0; i < 5; i++) tick();
    rock_hit = 1'b0;
    chk("saturate", score, 16'h9999);
    chk("sat_lives", 16'(lives), 16'd3);

    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk("ng1_score", score, 16'h0000);
    chk("ng1_respawn", 16'(respawn), 16'd1);
    chk("ng1_high", high_score, 16'h0000);
    tick();
    chk("ng1_respawn_off", 16'(respawn), 16'd0);

    rock_hit = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rock_hit = 1'b0;
    chk("rock3", score, 16'h0003);
    ship_hit = 1'b1;
    tick();
    ship_hit = 1'b0;
    chk("ship_lives", 16'(lives), 16'd2);
    chk("ship_inv", 16'(invulnerable), 16'd1);
    chk("ship_over", 16'(game_over), 16'd0);
    inv_cnt = 1;
    rs_cnt = 0;
    rs_at = 0;
    for (int i = 2; i <= 125; i++) begin
      if (i == 50) begin
        ship_hit = 1'b1;
        rock_hit = 1'b1;
      end
      tick();
      ship_hit = 1'b0;
      rock_hit = 1'b0;
      if (invulnerable) inv_cnt++;
      if (respawn) begin
        rs_cnt++;
        rs_at = i;
      end
      if (i == 50) begin
        chk("dying_hit_lives", 16'(lives), 16'd2);
        chk("dying_hit_score", score, 16'h0003);
      end
    end
    chk("inv_cycles", 16'(inv_cnt), 16'd120);
    chk("respawn_count", 16'(rs_cnt), 16'd1);
    chk("respawn_cycle", 16'(rs_at), 16'd121);
    chk_idle("after_dying", 16'h0003, 16'h0000, 2'd2);

    ship_hit = 1'b1;
    tick();
    ship_hit = 1'b0;
    chk("ship2_lives", 16'(lives), 16'd1);
    for (int i = 0; i < 121; i++) tick();
    chk("ship2_inv_off", 16'(invulnerable), 16'd0);
    rock_hit = 1'b1;
    for (int i = 0; i < 96; i++) tick();
    rock_hit = 1'b0;
    chk("score_99", score, 16'h0099);
    rock_hit = 1'b1;
    ship_hit = 1'b1;
    tick();
    rock_hit = 1'b0;
    ship_hit = 1'b0;
    chk("last_score", score, 16'h0100);
    chk("last_lives", 16'(lives), 16'd0);
    chk("last_over", 16'(game_over), 16'd1);
    chk("last_inv", 16'(invulnerable), 16'd0);
    chk("last_high_early", high_score, 16'h0000);
    tick();
    chk("last_high", high_score, 16'h0100);
    rock_hit = 1'b1;
    ship_hit = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rock_hit = 1'b0;
    ship_hit = 1'b0;
    chk("over_score", score, 16'h0100);
    chk("over_lives", 16'(lives), 16'd0);
    chk("over_hold", 16'(game_over), 16'd1);

    new_game = 1'b1;
    tick();
    chk("ng2_score", score, 16'h0000);
    chk("ng2_lives", 16'(lives), 16'd3);
    chk("ng2_over", 16'(game_over), 16'd0);
    chk("ng2_respawn", 16'(respawn), 16'd1);
    chk("ng2_high", high_score, 16'h0100);
    rs_cnt = 0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (respawn) rs_cnt++;
    end
    chk("ng2_held_respawn", 16'(rs_cnt), 16'd0);
    chk_idle("ng2_held", 16'h0000, 16'h0100, 2'd3);
    new_game = 1'b0;

    rock_hit = 1'b1;
    tick();
    tick();
    rock_hit = 1'b0;
    ship_hit = 1'b1;
    tick();
    ship_hit = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_inv", 16'(invulnerable), 16'd1);
    chk("pre_rst_score", score, 16'h0002);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("async_rst", 16'h0000, 16'h0000, 2'd3);
    tick();
    reset = 1'b0;
    rs_cnt = 0;
    for (int i = 0; i < 130; i++) begin
      tick();
      if (respawn || invulnerable) rs_cnt++;
    end
    chk("no_respawn_after_rst", 16'(rs_cnt), 16'd0);
    chk_idle("after_rst", 16'h0000, 16'h0000, 2'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/score_lives_ctrl.md
# score_lives_ctrl

Game-state controller for the Asteroids top level. It sits downstream of the collision detector and upstream of the 7-segment displays and the per-object reset lines. It turns one-cycle hit events into a saturating 4-digit BCD score and a lives count, and runs a play / dying / game-over state machine with a timed respawn. It also holds a high score across games and restarts the game on a rising edge of the new-game switch.

## Interface
- START_LIVES, 3: lives loaded on reset and on new game; range 1..3.
- RESPAWN_FRAMES, 120: length of the DYING state in clk_60hz cycles; range 1..255.
- ROCK_POINTS, 1: BCD points added per rock hit; range 1..9.

- clk_60hz  in  1  game logic clock, 60 Hz frame tick; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- new_game  in  1  level from the new-game switch; only a rising edge acts.
- rock_hit  in  1  one-cycle pulse per rock destroyed by a bullet.
- ship_hit  in  1  one-cycle pulse when a rock touches the ship.
- score  out  16  current score, 4 BCD digits, [15:12] most significant.
- high_score  out  16  best score so far, BCD.
- lives  out  2  remaining lives.
- game_over  out  1  high while in OVER.
- invulnerable  out  1  high while in DYING.
- respawn  out  1  one-cycle pulse that resets the ship and bullets.

## Operation
- States: PLAY, DYING, OVER. All outputs are registered.
- Reset values:
  - state PLAY, score 16'h0000, high_score 16'h0000, lives START_LIVES.
  - game_over 0, invulnerable 0, respawn 0, frame counter 0, new_game edge register 0.
- New-game edge detect:
  - ng_edge = new_game & ~ng_q, where ng_q is new_game registered every cycle.
  - Holding the switch high gives only one edge.
- ng_edge has top priority, in any state:
  - state PLAY, score 0, lives START_LIVES, respawn 1 for one cycle.
  - high_score is kept.
  - Hits in the same cycle are discarded.
- PLAY:
  - rock_hit: score ← BCD(score + ROCK_POINTS). Add to digit 0 and ripple decimal carries.
  - If the carry leaves digit 3, score saturates at 16'h9999.
  - ship_hit with lives > 1: lives − 1, go to DYING, counter ← RESPAWN_FRAMES − 1.
  - ship_hit with lives == 1: lives ← 0, go to OVER.
  - rock_hit and ship_hit in the same cycle: both take effect. The score increments and the life is lost.
- DYING:
  - invulnerable = 1. ship_hit and rock_hit are ignored.
  - The counter decrements each cycle.
  - The cycle after the counter reads 0: go to PLAY, respawn = 1 for that one cycle, invulnerable = 0.
- OVER:
  - game_over = 1. All hits are ignored.
  - Every cycle: high_score ← score if score > high_score. Compare as unsigned 16-bit; this is valid for BCD.
  - Stays in OVER until ng_edge.
- lives never underflows; ship_hit at lives 0 is unreachable because that case is OVER.

## Timing
- Latency for an input sampled at rising edge k:
  - Outputs change at edge k.
  - Exception: high_score changes at edge k+1 after game_over rises, because it compares the post-increment score.
- DYING lasts exactly RESPAWN_FRAMES cycles: invulnerable is high for RESPAWN_FRAMES cycles, and respawn is high on the first PLAY cycle that follows.
- respawn is never high for more than one consecutive cycle.
- Asynchronous reset mid-DYING or mid-OVER returns immediately to the reset values. There is no respawn pulse on reset.
- Back-to-back rock_hit pulses on consecutive cycles each add ROCK_POINTS; none are lost.

## Test plan
- Reset asserted then released, no stimulus -> score 0000, lives 3, high_score 0000, game_over 0, invulnerable 0, respawn 0 for 10 cycles.
- 12 consecutive rock_hit pulses -> score 16'h0012. Then enough further pulses to pass 9999 -> score holds 16'h9999.
- One ship_hit in PLAY (RESPAWN_FRAMES=120) -> lives 2 and invulnerable for 120 cycles. A ship_hit and a rock_hit at cycle 50 of DYING are ignored: lives stays 2, score unchanged. respawn pulses once, then PLAY.
- lives 1, score 0099, rock_hit and ship_hit in the same cycle -> score 0100, lives 0, game_over 1, high_score 0100 one cycle later. Further rock_hits leave score at 0100.
- In OVER with high_score 0100, new_game driven high and held 20 cycles:
  - score 0000, lives 3, game_over 0, respawn high for exactly one cycle, high_score still 0100.
  - No second restart while the switch stays high.
- Reset asserted in the middle of DYING -> all outputs return to reset values the same cycle. No respawn pulse after release.
